// File: rtl/br_pkg.sv
// Shared constants for branch resolution: func3 encodings, 2-bit counter states
// and the saturating counter step.
package br_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr + 2'd1;
    end
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluation from the flags of rs1 - rs2.
module br_cond_eval
  import br_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       cf,
  input  logic       zf,
  input  logic       vf,
  input  logic       sf,
  output logic       taken,
  output logic       illegal
);

  // cf is the no-borrow carry, so it means rs1 >= rs2 unsigned.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (func3)
      BR_BEQ:  taken = zf;
      BR_BNE:  taken = ~zf;
      BR_BLT:  taken = sf ^ vf;
      BR_BGE:  taken = ~(sf ^ vf);
      BR_BLTU: taken = ~cf;
      BR_BGEU: taken = cf;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with EX-stage resolution, registered flush/redirect
// and saturating branch/mispredict statistics.
module branch_predict_unit
  import br_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned IDX_LO      = 2,
  parameter logic [1:0]  CTR_INIT    = WNT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_func3,
  input  logic             cf,
  input  logic             zf,
  input  logic             vf,
  input  logic             sf,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  output logic             br_taken,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IdxW-1:0]  if_idx, ex_idx;
  logic             cond_taken, cond_illegal;
  logic             live, resolve, mispredict;
  logic             flush_q, illegal_q;
  logic [XLEN-1:0]  redirect_q;
  logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;
  logic             unused_if_pc;

  assign unused_if_pc = ^if_pc;

  assign if_idx     = if_pc[IDX_LO +: IdxW];
  assign ex_idx     = ex_pc[IDX_LO +: IdxW];
  assign pred_taken = bht_q[if_idx][1];

  br_cond_eval u_cond (
    .func3   (ex_func3),
    .cf      (cf),
    .zf      (zf),
    .vf      (vf),
    .sf      (sf),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign br_taken = ex_valid && ex_is_branch && cond_taken;

  // While flush is high the EX slot holds a wrong-path instruction.
  assign live       = ex_valid && ex_is_branch && !flush_q;
  assign resolve    = live && !cond_illegal;
  assign mispredict = resolve && (br_taken != ex_pred_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CTR_INIT;
      end
    end else if (resolve) begin
      bht_q[ex_idx] <= ctr_next(bht_q[ex_idx], br_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q    <= 1'b0;
      illegal_q  <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q   <= mispredict;
      illegal_q <= live && cond_illegal;
      if (mispredict) begin
        redirect_q <= br_taken ? ex_target : ex_pc + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (resolve && (br_cnt_q != '1)) begin
        br_cnt_q <= br_cnt_q + CNT_W'(1);
      end
      if (mispredict && (mis_cnt_q != '1)) begin
        mis_cnt_q <= mis_cnt_q + CNT_W'(1);
      end
    end
  end

  assign flush       = flush_q;
  assign illegal_br  = illegal_q;
  assign redirect_pc = redirect_q;
  assign br_count    = br_cnt_q;
  assign mis_count   = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboarded random + directed bench for branch_predict_unit, with a second
// instance at CNT_W=4 to exercise statistics saturation.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc = '0, ex_pc = '0, ex_target = '0;
  logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_pred_taken = 1'b0;
  logic [2:0]  ex_func3 = '0;
  logic        cf = 1'b0, zf = 1'b0, vf = 1'b0, sf = 1'b0;

  logic        pred_taken, br_taken, flush, illegal_br;
  logic [31:0] redirect_pc, br_count, mis_count;
  logic        pred4, brt4, flush4, ill4;
  logic [31:0] redir4;
  logic [3:0]  brc4, misc4;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_func3(ex_func3),
    .cf(cf), .zf(zf), .vf(vf), .sf(sf), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .br_taken(br_taken), .flush(flush),
    .redirect_pc(redirect_pc), .illegal_br(illegal_br), .br_count(br_count),
    .mis_count(mis_count)
  );

  branch_predict_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred4),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_func3(ex_func3),
    .cf(cf), .zf(zf), .vf(vf), .sf(sf), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .br_taken(brt4), .flush(flush4),
    .redirect_pc(redir4), .illegal_br(ill4), .br_count(brc4), .mis_count(misc4)
  );

  typedef struct {
    int          id;
    logic        pred, brt, flush, ill;
    logic [31:0] redir, brc, misc;
    logic [3:0]  brc4, misc4;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_id  = 0;

  // Reference model: counters as integers 0..3, stats as plain counts.
  int          m_bht [64];
  bit          m_flush, m_ill;
  logic [31:0] m_redir;
  int unsigned m_br, m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_flush = 0; m_ill = 0; m_redir = '0; m_br = 0; m_mis = 0;
  endfunction

  // Direction from the operands themselves, not from the flags.
  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b, output bit ill);
    ill = 0;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: begin ill = 1; return 0; end
    endcase
  endfunction

  function automatic exp_t snapshot(input bit brt);
    exp_t e;
    e.id    = cyc_id;
    e.pred  = (m_bht[idx_of(if_pc)] >= 2);
    e.brt   = brt;
    e.flush = m_flush;
    e.ill   = m_ill;
    e.redir = m_redir;
    e.brc   = m_br;
    e.misc  = m_mis;
    e.brc4  = 4'((m_br > 15) ? 15 : m_br);
    e.misc4 = 4'((m_mis > 15) ? 15 : m_mis);
    return e;
  endfunction

  task automatic reset_cycle(input logic [31:0] ipc);
    @(posedge clk); #1;
    rst_n = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0; if_pc = ipc;
    model_reset();
    cyc_id++;
    q.push_back(snapshot(1'b0));
  endtask

  task automatic drive(input logic [31:0] ipc, input bit v, input bit isb,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] epc, input logic [31:0] tgt, input bit ep);
    logic [32:0] diff;
    bit          t, ill, live, mis;
    int          k;
    @(posedge clk); #1;
    diff = {1'b0, a} + {1'b0, ~b} + 33'd1;
    rst_n = 1'b1; if_pc = ipc; ex_valid = v; ex_is_branch = isb; ex_func3 = f3;
    ex_pc = epc; ex_target = tgt; ex_pred_taken = ep;
    cf = diff[32]; zf = (diff[31:0] == 0); sf = diff[31];
    vf = (a[31] != b[31]) && (diff[31] != a[31]);
    t = ref_taken(f3, a, b, ill);
    cyc_id++;
    q.push_back(snapshot(v && isb && t));
    live = v && isb && !m_flush;
    mis  = live && !ill && (t != ep);
    if (live && !ill) begin
      k = idx_of(epc);
      m_bht[k] = t ? ((m_bht[k] == 3) ? 3 : m_bht[k] + 1) : ((m_bht[k] == 0) ? 0 : m_bht[k] - 1);
      m_br++;
      if (mis) begin
        m_mis++;
        m_redir = t ? tgt : epc + 32'd4;
      end
    end
    m_flush = mis;
    m_ill   = live && ill;
  endtask

  task automatic idle(input logic [31:0] ipc);
    drive(ipc, 0, 0, 3'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%h, expected 0x%h", name, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      check("pred_taken",  e.id, 32'(pred_taken),  32'(e.pred));
      check("br_taken",    e.id, 32'(br_taken),    32'(e.brt));
      check("flush",       e.id, 32'(flush),       32'(e.flush));
      check("illegal_br",  e.id, 32'(illegal_br),  32'(e.ill));
      check("redirect_pc", e.id, redirect_pc,      e.redir);
      check("br_count",    e.id, br_count,         e.brc);
      check("mis_count",   e.id, mis_count,        e.misc);
      check("pred_taken4", e.id, 32'(pred4),       32'(e.pred));
      check("br_taken4",   e.id, 32'(brt4),        32'(e.brt));
      check("flush4",      e.id, 32'(flush4),      32'(e.flush));
      check("illegal_br4", e.id, 32'(ill4),        32'(e.ill));
      check("redirect4",   e.id, redir4,           e.redir);
      check("br_count4",   e.id, 32'(brc4),        32'(e.brc4));
      check("mis_count4",  e.id, 32'(misc4),       32'(e.misc4));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, ipc, epc;
    bit          ep, dummy;
    model_reset();
    reset_cycle(32'h100);
    reset_cycle(32'h100);

    // Mispredicted BEQ, squashed mispredicting BNE, then saturation to ST.
    drive(32'h100, 1, 1, 3'd0, 5, 5, 32'h100, 32'h200, 0);
    drive(32'h100, 1, 1, 3'd1, 5, 5, 32'h100, 32'h300, 1);
    drive(32'h100, 1, 1, 3'd0, 5, 5, 32'h100, 32'h200, 1);
    drive(32'h100, 1, 1, 3'd0, 5, 5, 32'h100, 32'h200, 1);
    drive(32'h100, 1, 1, 3'd1, 5, 5, 32'h100, 32'h200, 1);
    idle(32'h100);
    idle(32'h100);

    // BLTU taken as predicted, BGEU not taken against prediction, wrap-around.
    drive(32'h40, 1, 1, 3'd6, 1, 2, 32'h40, 32'h80, 1);
    drive(32'h40, 1, 1, 3'd7, 1, 2, 32'h44, 32'h80, 1);
    idle(32'h44);
    drive(32'h40, 1, 1, 3'd7, 1, 2, 32'hFFFF_FFFC, 32'h80, 1);
    idle(32'h40);

    // Illegal func3.
    drive(32'h40, 1, 1, 3'd2, 7, 7, 32'h40, 32'h90, 1);
    drive(32'h40, 1, 1, 3'd3, 7, 8, 32'h40, 32'h90, 0);
    idle(32'h40);

    // Same-cycle lookup/update at index 5: no bypass.
    drive(32'h14, 1, 1, 3'd0, 3, 3, 32'h14, 32'h500, 0);
    idle(32'h14);
    idle(32'h14);

    // Reset dropping a pending flush.
    drive(32'h14, 1, 1, 3'd4, 32'hFFFF_FFFF, 1, 32'h18, 32'h600, 0);
    reset_cycle(32'h14);
    idle(32'h14);

    for (int i = 0; i < 400; i++) begin
      a = 32'($urandom_range(0, 3));
      b = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a ^= 32'h8000_0000;
      if ($urandom_range(0, 1) == 1) b ^= 32'h8000_0000;
      ipc = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      epc = (i % 97 == 50) ? 32'hFFFF_FFFC : 32'h100 + 32'($urandom_range(0, 7)) * 4;
      ep  = ($urandom_range(0, 1) == 1) ? (m_bht[idx_of(epc)] >= 2) : bit'($urandom_range(0, 1));
      dummy = 0;
      drive(ipc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            3'($urandom_range(0, 7)), a, b, epc, $urandom, ep);
      if (i == 200) reset_cycle(ipc);
    end
    idle(32'h100);
    idle(32'h100);

    @(negedge clk); #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
